// File: rtl/eeg_aram_pkg.sv
// Shared encodings and default widths for the ARAM transfer master.
// Commands, FSM states and parameter defaults live here.
package eeg_aram_pkg;

    localparam int DEF_ADD_AW   = 12;
    localparam int DEF_DAT_DW   = 8;
    localparam int DEF_RD_DEPTH = 4;

    localparam logic [1:0] CMD_WRITE = 2'b01;
    localparam logic [1:0] CMD_READ  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WRITE  = 2'd1,
        ST_RADD   = 2'd2,
        ST_RDRAIN = 2'd3
    } state_t;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/eeg_aram_mst_fifo.sv
// Read-return FIFO: synchronous, first-word-fall-through, with occupancy.
// Write is refused when full unless a pop frees a slot in the same cycle.
module eeg_aram_mst_fifo
    import eeg_aram_pkg::*;
#(
    parameter int DW    = DEF_DAT_DW + 1,
    parameter int DEPTH = DEF_RD_DEPTH,
    localparam int CW   = cnt_w(DEPTH),
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic [DW-1:0] i_din,
    input  logic          i_pop,
    output logic [DW-1:0] o_dout,
    output logic          o_empty,
    output logic [CW-1:0] o_cnt
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wp;
    logic [PW-1:0] r_rp;
    logic [CW-1:0] r_cnt;
    logic          w_full;
    logic          w_wr;
    logic          w_rd;

    assign o_empty = (r_cnt == '0);
    assign w_full  = (r_cnt == CW'(DEPTH));
    assign w_rd    = i_pop && !o_empty;
    assign w_wr    = i_push && (!w_full || w_rd);
    assign o_dout  = r_mem[r_rp];
    assign o_cnt   = r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_wr) begin
                r_mem[r_wp] <= i_din;
                r_wp <= (r_wp == PW'(DEPTH - 1)) ? '0 : r_wp + PW'(1);
            end
            if (w_rd) begin
                r_rp <= (r_rp == PW'(DEPTH - 1)) ? '0 : r_rp + PW'(1);
            end
            unique case ({w_wr, w_rd})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/eeg_aram_mst.sv
// ARAM transfer master: config-driven burst writes and credit-limited reads.
// Define EEG_ARAM_MST_LST_CHK_EN to enable the sticky ERR_LST checker.
module eeg_aram_mst
    import eeg_aram_pkg::*;
#(
    parameter int ADD_AW   = DEF_ADD_AW,
    parameter int DAT_DW   = DEF_DAT_DW,
    parameter int RD_DEPTH = DEF_RD_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              CFG_INFO_VLD,
    output logic              CFG_INFO_RDY,
    input  logic [1:0]        CFG_INFO_CMD,
    input  logic [ADD_AW-1:0] CFG_BASE_ADD,
    input  logic [ADD_AW-1:0] CFG_XFER_LEN,
    output logic              IS_IDLE,
    input  logic              SRC_DAT_VLD,
    output logic              SRC_DAT_RDY,
    input  logic [DAT_DW-1:0] SRC_DAT_DAT,
    output logic              ETOA_DAT_VLD,
    output logic              ETOA_DAT_LST,
    input  logic              ETOA_DAT_RDY,
    output logic [ADD_AW-1:0] ETOA_DAT_ADD,
    output logic [DAT_DW-1:0] ETOA_DAT_DAT,
    output logic              ETOA_ADD_VLD,
    output logic              ETOA_ADD_LST,
    input  logic              ETOA_ADD_RDY,
    output logic [ADD_AW-1:0] ETOA_ADD_ADD,
    input  logic              ATOE_DAT_VLD,
    input  logic              ATOE_DAT_LST,
    output logic              ATOE_DAT_RDY,
    input  logic [DAT_DW-1:0] ATOE_DAT_DAT,
    output logic              SNK_DAT_VLD,
    output logic              SNK_DAT_LST,
    input  logic              SNK_DAT_RDY,
    output logic [DAT_DW-1:0] SNK_DAT_DAT,
    output logic              ERR_LST
);

    localparam int CW = cnt_w(RD_DEPTH);

    state_t            r_state;
    state_t            w_nxt;
    logic [ADD_AW-1:0] r_base;
    logic [ADD_AW-1:0] r_len;
    logic [ADD_AW-1:0] r_idx;
    logic [ADD_AW-1:0] r_ret;
    logic [CW-1:0]     r_outst;
    logic [CW-1:0]     w_occ;
    logic [ADD_AW-1:0] w_addr;
    logic              w_last;
    logic              w_ret_lst;
    logic              w_credit;
    logic              w_cfg_hs;
    logic              w_wr_hs;
    logic              w_ad_hs;
    logic              w_push;
    logic              w_pop;
    logic              w_empty;
    logic [DAT_DW:0]   w_dout;

    assign IS_IDLE      = (r_state == ST_IDLE);
    assign CFG_INFO_RDY = IS_IDLE;
    assign ATOE_DAT_RDY = 1'b1;

    assign w_addr    = r_base + r_idx;
    assign w_last    = (r_idx == r_len);
    assign w_ret_lst = (r_ret == r_len);
    assign w_cfg_hs  = CFG_INFO_VLD && IS_IDLE;

    // Credit covers in-flight addresses plus parked data, so FIFO cannot overflow.
    assign w_credit = ({1'b0, r_outst} + {1'b0, w_occ})
                      < (CW + 1)'(RD_DEPTH);

    assign w_wr_hs = (r_state == ST_WRITE)
                     && SRC_DAT_VLD && ETOA_DAT_RDY;
    assign w_ad_hs = (r_state == ST_RADD)
                     && w_credit && ETOA_ADD_RDY;

    // Returns arriving outside a read (e.g. after reset) are dropped.
    assign w_push = ATOE_DAT_VLD
                    && ((r_state == ST_RADD) || (r_state == ST_RDRAIN));
    assign w_pop  = !w_empty && SNK_DAT_RDY;

    assign SNK_DAT_VLD = !w_empty;
    assign SNK_DAT_LST = !w_empty && w_dout[DAT_DW];
    assign SNK_DAT_DAT = w_empty ? '0 : w_dout[DAT_DW-1:0];

    eeg_aram_mst_fifo #(
        .DW    (DAT_DW + 1),
        .DEPTH (RD_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_din   ({w_ret_lst, ATOE_DAT_DAT}),
        .i_pop   (w_pop),
        .o_dout  (w_dout),
        .o_empty (w_empty),
        .o_cnt   (w_occ)
    );

    always_comb begin
        w_nxt        = r_state;
        SRC_DAT_RDY  = 1'b0;
        ETOA_DAT_VLD = 1'b0;
        ETOA_DAT_LST = 1'b0;
        ETOA_DAT_ADD = '0;
        ETOA_DAT_DAT = '0;
        ETOA_ADD_VLD = 1'b0;
        ETOA_ADD_LST = 1'b0;
        ETOA_ADD_ADD = '0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_cfg_hs) begin
                    if (CFG_INFO_CMD == CMD_WRITE) begin
                        w_nxt = ST_WRITE;
                    end else if (CFG_INFO_CMD == CMD_READ) begin
                        w_nxt = ST_RADD;
                    end
                end
            end
            ST_WRITE: begin
                ETOA_DAT_VLD = SRC_DAT_VLD;
                SRC_DAT_RDY  = ETOA_DAT_RDY;
                ETOA_DAT_LST = w_last;
                ETOA_DAT_ADD = w_addr;
                ETOA_DAT_DAT = SRC_DAT_DAT;
                if (w_wr_hs && w_last) begin
                    w_nxt = ST_IDLE;
                end
            end
            ST_RADD: begin
                ETOA_ADD_VLD = w_credit;
                ETOA_ADD_LST = w_last;
                ETOA_ADD_ADD = w_addr;
                if (w_ad_hs && w_last) begin
                    w_nxt = ST_RDRAIN;
                end
            end
            ST_RDRAIN: begin
                if (w_pop && w_dout[DAT_DW]) begin
                    w_nxt = ST_IDLE;
                end
            end
            default: w_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_base  <= '0;
            r_len   <= '0;
            r_idx   <= '0;
            r_ret   <= '0;
            r_outst <= '0;
        end else begin
            r_state <= w_nxt;
            if (w_cfg_hs) begin
                r_base <= CFG_BASE_ADD;
                r_len  <= CFG_XFER_LEN;
                r_idx  <= '0;
                r_ret  <= '0;
            end else begin
                if (w_wr_hs || w_ad_hs) begin
                    r_idx <= r_idx + ADD_AW'(1);
                end
                if (w_push) begin
                    r_ret <= r_ret + ADD_AW'(1);
                end
            end
            unique case ({w_ad_hs, w_push})
                2'b10:   r_outst <= r_outst + CW'(1);
                2'b01:   r_outst <= r_outst - CW'(1);
                default: r_outst <= r_outst;
            endcase
        end
    end

`ifdef EEG_ARAM_MST_LST_CHK_EN
    logic r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_push && (ATOE_DAT_LST != w_ret_lst)) begin
            r_err <= 1'b1;
        end
    end

    assign ERR_LST = r_err;
`else
    logic w_unused_lst;

    assign w_unused_lst = ATOE_DAT_LST;
    assign ERR_LST      = 1'b0;
`endif

endmodule
